// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 1;
  localparam int unsigned UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// AXI-Stream byte channel feeding the buffered transmitter.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic                      s_axis_tvalid;
  logic [UART_DATA_BITS-1:0] s_axis_tdata;
  logic                      s_axis_tready;

  modport slave  (input  s_axis_tvalid, input  s_axis_tdata, output s_axis_tready);
  modport master (output s_axis_tvalid, output s_axis_tdata, input  s_axis_tready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on o_rdata while not empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_DATA_BITS,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign o_full   = (level_q == LVL_W'(DEPTH));
  assign o_empty  = (level_q == '0);
  assign o_level  = level_q;
  assign o_rdata  = mem_q[rd_ptr_q];
  assign push_ok  = i_push && !o_full;
  assign pop_ok   = i_pop && !o_empty;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define which words are valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter with AXI-Stream back-pressure; frames go back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  uart_tx_buffered_if.slave               s_axis,
  output logic                            o_txd,
  output logic                            o_txd_busy,
  output logic                            o_txd_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_level
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_STOP  = ST_STOP;

  logic [1:0]                state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d, baud_inc;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic [UART_DATA_BITS-1:0] head;
  logic                      full, empty, push, pop, baud_last, bit_last;

  assign s_axis.s_axis_tready = i_rst_n && !full;
  assign push = s_axis.s_axis_tvalid && s_axis.s_axis_tready;

  uart_sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (s_axis.s_axis_tdata),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_fifo_level)
  );

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BIT_W'(UART_DATA_BITS - 1));
  assign baud_inc  = baud_last ? '0 : baud_q + 1'b1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = baud_inc;
        if (baud_last) state_d = S_DATA;
      end
      S_DATA: begin
        baud_d = baud_inc;
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_last) state_d = S_STOP;
        end
      end
      default: begin
        baud_d = baud_inc;
        // Chain straight into the next start bit so a queued stream has no idle gap.
        if (baud_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // Line outputs are registered copies of the current state, one cycle behind the FSM.
  always_comb begin
    txd_d  = 1'b1;
    if (state_q == S_START)     txd_d = 1'b0;
    else if (state_q == S_DATA) txd_d = shift_q[0];
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_STOP) && baud_last;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_txd      = txd_q;
  assign o_txd_busy = busy_q;
  assign o_txd_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized and directed bench for uart_tx_buffered against a frame-level reference model.
module tb_uart_tx_buffered;

  localparam int CPB   = 87;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       o_txd, o_txd_busy, o_txd_done;
  logic [4:0] o_fifo_level;
  logic       txd2, busy2, done2;
  logic [1:0] level2;

  uart_tx_buffered_if axis_if ();
  uart_tx_buffered_if axis2_if ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .s_axis(axis_if),
    .o_txd(o_txd), .o_txd_busy(o_txd_busy), .o_txd_done(o_txd_done), .o_fifo_level(o_fifo_level)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .s_axis(axis2_if),
    .o_txd(txd2), .o_txd_busy(busy2), .o_txd_done(done2), .o_fifo_level(level2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  bit         ser_act = 1'b0;
  int         ser_k = 0;
  logic [7:0] ser_b = '0;
  logic       e_txd = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  bit         started = 1'b0;
  bit         push_ok;
  int         cyc = 0;

  function automatic logic bitval(input logic [7:0] b, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    started = 1'b1;
    if (!rst_n) begin
      mq.delete();
      sent_q.delete();
      ser_act = 1'b0;
      ser_k   = 0;
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      push_ok = axis_if.s_axis_tvalid && (mq.size() != DEPTH);
      e_txd  = ser_act ? bitval(ser_b, ser_k) : 1'b1;
      e_busy = ser_act;
      e_done = ser_act && (ser_k == FRAME - 1);
      if (ser_act && ser_k != FRAME - 1) begin
        ser_k++;
      end else if (mq.size() != 0) begin
        ser_b = mq.pop_front();
        sent_q.push_back(ser_b);
        ser_act = 1'b1;
        ser_k   = 0;
      end else begin
        ser_act = 1'b0;
      end
      if (push_ok) mq.push_back(axis_if.s_axis_tdata);
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_cnt = 0, spaced = 0, last_done = -100000;
  bit saw_full = 1'b0, saw_refill = 1'b0;

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("txd", o_txd, e_txd);
      check("busy", o_txd_busy, e_busy);
      check("done", o_txd_done, e_done);
      check("level", o_fifo_level, mq.size());
      check("tready", axis_if.s_axis_tready, rst_n && (mq.size() != DEPTH));
      if (o_txd_done) begin
        done_cnt++;
        if (cyc - last_done == FRAME) spaced++;
        last_done = cyc;
      end
      if (rst_n && o_fifo_level == 5'd16 && !axis_if.s_axis_tready) saw_full = 1'b1;
      if (saw_full && axis_if.s_axis_tready) saw_refill = 1'b1;
    end
  end

  // ---------------- independent line decoder ----------------
  bit         d_act = 1'b0, prev_txd = 1'b1;
  int         d_cnt = 0, rx_cnt = 0;
  logic [7:0] d_byte = '0, last_rx = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      d_act = 1'b0;
      prev_txd = 1'b1;
    end else begin
      if (!d_act && prev_txd && o_txd === 1'b0) begin
        d_act = 1'b1;
        d_cnt = 0;
      end
      if (d_act) begin
        if (d_cnt % CPB == CPB / 2) begin
          if (d_cnt / CPB == 0) check("rx_start_bit", o_txd, 1'b0);
          else if (d_cnt / CPB <= 8) d_byte[d_cnt/CPB-1] = o_txd;
          else begin
            check("rx_stop_bit", o_txd, 1'b1);
            check("rx_expected_frame", sent_q.size() != 0, 1'b1);
            if (sent_q.size() != 0) check("rx_byte", d_byte, sent_q.pop_front());
            last_rx = d_byte;
            rx_cnt++;
            d_act = 1'b0;
          end
        end
        d_cnt++;
      end
      prev_txd = o_txd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [7:0] b);
    int t = 0;
    axis_if.s_axis_tvalid = 1'b1;
    axis_if.s_axis_tdata  = b;
    while (!axis_if.s_axis_tready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", t < 5000, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((mq.size() != 0 || ser_act || o_txd_busy) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", t < 30000, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  logic       rec_txd [25];
  logic       rec_busy[25];
  logic       rec_done[25];

  initial begin
    int acc, t, low, r0, d0, first_low, low_cnt, busy_cnt, done_off, dn2;
    logic [7:0] b2, e_byte;

    rst_n = 1'b0;
    axis_if.s_axis_tvalid  = 1'b0; axis_if.s_axis_tdata  = '0;
    axis2_if.s_axis_tvalid = 1'b0; axis2_if.s_axis_tdata = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", o_txd, 1'b1);
    check("rst_busy", o_txd_busy, 1'b0);
    check("rst_done", o_txd_done, 1'b0);
    check("rst_level", o_fifo_level, 0);
    check("rst_tready", axis_if.s_axis_tready, 1'b0);
    check("rst_txd2", txd2, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", axis_if.s_axis_tready, 1'b1);

    // CLKS_PER_BIT=2 instance, byte 0xFF: 20-cycle frame, start low for 2 cycles.
    check("tready2", axis2_if.s_axis_tready, 1'b1);
    axis2_if.s_axis_tvalid = 1'b1;
    axis2_if.s_axis_tdata  = 8'hFF;
    @(negedge clk);
    axis2_if.s_axis_tvalid = 1'b0;
    rec_txd[0] = txd2; rec_busy[0] = busy2; rec_done[0] = done2;
    for (int off = 1; off < 25; off++) begin
      @(negedge clk);
      rec_txd[off] = txd2; rec_busy[off] = busy2; rec_done[off] = done2;
    end
    first_low = -1; low_cnt = 0; busy_cnt = 0; done_off = -1; dn2 = 0;
    for (int off = 0; off < 25; off++) begin
      if (!rec_txd[off]) begin
        low_cnt++;
        if (first_low < 0) first_low = off;
      end
      if (rec_busy[off]) busy_cnt++;
      if (rec_done[off]) begin
        dn2++;
        done_off = off;
      end
    end
    for (int i = 0; i < 8; i++) b2[i] = rec_txd[2 + 2 * (i + 1)];
    check("cpb2_first_low", first_low, 2);
    check("cpb2_low_cycles", low_cnt, 2);
    check("cpb2_frame_len", busy_cnt, 20);
    check("cpb2_done_offset", done_off, 21);
    check("cpb2_done_count", dn2, 1);
    check("cpb2_byte", b2, 8'hFF);

    // Single byte 0x55.
    r0 = rx_cnt; d0 = done_cnt;
    push(8'h55);
    acc = cyc;
    axis_if.s_axis_tvalid = 1'b0;
    t = 0;
    while (o_txd !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("start_latency", cyc - acc, 2);
    low = 0;
    while (o_txd === 1'b0 && low < 1000) begin
      @(negedge clk);
      low++;
    end
    check("start_bit_len", low, CPB);
    wait_idle();
    check("single_done", done_cnt - d0, 1);
    check("single_rx_cnt", rx_cnt - r0, 1);
    check("single_rx", last_rx, 8'h55);

    // Burst 0x00..0x0F with tvalid held.
    r0 = rx_cnt; d0 = done_cnt; t = spaced;
    for (int i = 0; i < 16; i++) push(8'(i));
    axis_if.s_axis_tvalid = 1'b0;
    wait_idle();
    check("burst_done", done_cnt - d0, 16);
    check("burst_rx_cnt", rx_cnt - r0, 16);
    check("burst_back_to_back", spaced - t, 15);
    check("burst_last", last_rx, 8'h0F);

    // Overfill: 20 bytes while a frame is on the line.
    r0 = rx_cnt;
    push(8'($urandom_range(0, 255)));
    axis_if.s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    saw_full = 1'b0; saw_refill = 1'b0;
    for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
    axis_if.s_axis_tvalid = 1'b0;
    check("overfill_full_seen", saw_full, 1'b1);
    check("overfill_refill_seen", saw_refill, 1'b1);
    wait_idle();
    check("overfill_rx_cnt", rx_cnt - r0, 21);

    // Push coinciding with a pop while level is 3.
    r0 = rx_cnt;
    push(8'hA1);
    acc = cyc;
    push(8'hB2); push(8'hC3); push(8'hD4);
    axis_if.s_axis_tvalid = 1'b0;
    t = 0;
    while (cyc < acc + FRAME && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("simul_level_before", o_fifo_level, 3);
    check("simul_tready", axis_if.s_axis_tready, 1'b1);
    axis_if.s_axis_tvalid = 1'b1;
    axis_if.s_axis_tdata  = 8'hE5;
    @(negedge clk);
    axis_if.s_axis_tvalid = 1'b0;
    check("simul_level_after", o_fifo_level, 3);
    wait_idle();
    check("simul_rx_cnt", rx_cnt - r0, 5);
    check("simul_last", last_rx, 8'hE5);

    // Reset in the middle of data bit 3 of 0xA3 with 4 bytes queued.
    push(8'hA3);
    acc = cyc;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    axis_if.s_axis_tvalid = 1'b0;
    while (cyc < acc + 2 + CPB * 4 + 40) @(negedge clk);
    check("pre_reset_level", o_fifo_level, 4);
    r0 = rx_cnt; d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_txd", o_txd, 1'b1);
    check("mid_rst_level", o_fifo_level, 0);
    check("mid_rst_tready", axis_if.s_axis_tready, 1'b0);
    check("mid_rst_busy", o_txd_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("no_done_after_rst", done_cnt - d0, 0);
    check("no_rx_after_rst", rx_cnt - r0, 0);
    push(8'h3C);
    axis_if.s_axis_tvalid = 1'b0;
    wait_idle();
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_rx", last_rx, 8'h3C);

    // Random bytes with random idle gaps.
    r0 = rx_cnt;
    for (int i = 0; i < 12; i++) begin
      axis_if.s_axis_tvalid = 1'b0;
      repeat ($urandom_range(0, 1200)) @(negedge clk);
      e_byte = 8'($urandom_range(0, 255));
      push(e_byte);
    end
    axis_if.s_axis_tvalid = 1'b0;
    wait_idle();
    check("random_rx_cnt", rx_cnt - r0, 12);
    check("random_last", last_rx, e_byte);
    check("scoreboard_empty", sent_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes on an AXI-Stream slave port into an internal FIFO and serializes them 8N1, LSB first, on `o_txd` with true back-pressure. Sits wherever a byte source (e.g. `uart_rx` loopback, command engine) cannot tolerate the single-byte, unbuffered acceptance of `uart_tx`. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per serial bit (10 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `i_clk`  in  1  sole clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `o_s_axis_tready`  out  1  high when FIFO not full and not in reset.
- `i_s_axis_tvalid`  in  1  byte valid.
- `i_s_axis_tdata`  in  8  byte to send.
- `o_txd`  out  1  serial line, idle high.
- `o_txd_busy`  out  1  high while a frame (start through stop) is on the line.
- `o_txd_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `o_fifo_level`  out  $clog2(FIFO_DEPTH+1)  bytes currently queued (excludes the byte being shifted).

## Operation
- Push: on any edge with `i_s_axis_tvalid && o_s_axis_tready`, `i_s_axis_tdata` is written; level +1.
- `o_s_axis_tready` = `i_rst_n && (level != FIFO_DEPTH)`; combinational from registered level. No write when full, even if a pop occurs that cycle (no full-bypass).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `o_txd`=1, busy=0. If level ≠ 0: pop head into shift register, bit counter ← 0, baud counter ← 0, go START.
  - START: `o_txd`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `o_txd`=shift[0]; after CLKS_PER_BIT cycles shift right, bit counter +1; after bit 7 go STOP.
  - STOP: `o_txd`=1 for CLKS_PER_BIT cycles; on the final cycle pulse `o_txd_done`; if level ≠ 0 pop and go directly to START, else go IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps; width $clog2(CLKS_PER_BIT).
- Simultaneous push and pop: level unchanged; both occur.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset (any state, mid-frame included): on the reset edge state ← IDLE, FIFO emptied (level 0), counters 0, `o_txd` 1, busy 0, done 0; partial frame abandoned, no completion pulse.

## Timing
- All outputs except `o_s_axis_tready` are registered.
- Reset values: `o_txd`=1, `o_txd_busy`=0, `o_txd_done`=0, `o_fifo_level`=0, `o_s_axis_tready`=0 while `i_rst_n`=0, 1 on the first cycle after release.
- Latency, idle with empty FIFO: byte accepted at edge N → level 1 after N → popped at edge N+1 → `o_txd` low and busy high after edge N+2.
- Frame length exactly 10·CLKS_PER_BIT cycles from `o_txd` falling to the end of stop bit.
- Back-to-back: next start bit begins the cycle immediately after the previous stop bit's last cycle; continuous stream period 10·CLKS_PER_BIT.
- `o_txd_done` high exactly one cycle per completed frame, coincident with the last stop-bit cycle.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE/START/DATA/STOP), frame constants (8 data bits, 1 stop bit).
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/level); reusable for a future buffered receiver. Serializer FSM stays in the top.

## Test plan
- Single byte 0x55, CLKS_PER_BIT=87 → `o_txd` low 2 cycles after accept; bits 1,0,1,0,1,0,1,0 each 87 cycles; stop high; one `o_txd_done`; `uart_rx` checker reads 0x55.
- Burst 0x00..0x0F (16 bytes) with tvalid held → all accepted, no gap between frames (start follows stop in next cycle), checker sees 0x00..0x0F in order, 16 done pulses.
- Overfill: 20 bytes pushed while first frame active, FIFO_DEPTH=16 → tready drops when level=16, rises after next pop, no byte lost or duplicated.
- Push on the same cycle as a pop with level=3 → level stays 3; transmitted order preserved.
- Reset pulse mid-DATA of byte 0xA3 with 4 queued → `o_txd`=1, level 0, tready 0 during reset; no done pulse; next byte 0x3C after release transmits cleanly.
- CLKS_PER_BIT=2, byte 0xFF → frame 20 cycles, start low 2 cycles, checker reads 0xFF.
